// File: rtl/multiplier_datapath_if.sv
// Command and result bundle between the shift-add multiplier controller and its datapath.
// The controller drives commands and the operand; the datapath returns registers A, B, X and M.
interface multiplier_datapath_if;
    logic       Clr_Ld;
    logic       ClearA;
    logic       Add;
    logic       Sub;
    logic       Shift;
    logic [7:0] S;
    logic [7:0] Aval;
    logic [7:0] Bval;
    logic       X;
    logic       M;

    modport master (
        output Clr_Ld, ClearA, Add, Sub, Shift, S,
        input  Aval, Bval, X, M
    );

    modport slave (
        input  Clr_Ld, ClearA, Add, Sub, Shift, S,
        output Aval, Bval, X, M
    );
endinterface

// File: rtl/multiplier_datapath.sv
// Accumulator/multiplier register datapath for the 8-bit signed shift-add multiplier.
// Holds {X,A,B}; executes one controller command per Clk edge with fixed priority.
module multiplier_datapath (
    input  logic                  Clk,
    input  logic                  Reset,
    multiplier_datapath_if.slave  bus
);

    logic [7:0] a_reg;
    logic [7:0] b_reg;
    logic       x_reg;
    logic [8:0] operand9;
    logic [8:0] sum9;

    // Subtraction reuses the adder: invert the sign-extended operand and inject carry-in.
    // NOTE: every always_comb output is assigned on all paths, so no latch is inferred.
    always_comb begin
        operand9 = {bus.S[7], bus.S};
        if (bus.Sub) begin
            operand9 = ~{bus.S[7], bus.S};
        end
        sum9 = {a_reg[7], a_reg} + operand9 + {8'b0, bus.Sub};
    end

    // NOTE: non-blocking assignments so the shift sees pre-edge A, B and X together.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            a_reg <= 8'h00;
            b_reg <= 8'h00;
            x_reg <= 1'b0;
        end else if (bus.Clr_Ld || bus.ClearA) begin
            if (bus.ClearA) begin
                a_reg <= 8'h00;
                x_reg <= 1'b0;
            end
            if (bus.Clr_Ld) begin
                b_reg <= bus.S;
            end
        end else if (bus.Sub || bus.Add) begin
            a_reg <= sum9[7:0];
            x_reg <= sum9[8];
        end else if (bus.Shift) begin
            a_reg <= {x_reg, a_reg[7:1]};
            b_reg <= {a_reg[0], b_reg[7:1]};
        end
    end

    assign bus.Aval = a_reg;
    assign bus.Bval = b_reg;
    assign bus.X    = x_reg;
    assign bus.M    = b_reg[0];

endmodule

// File: tb/tb_multiplier_datapath.sv
// Directed bench for multiplier_datapath: a command/expectation table applied in order,
// then hold, mid-run reset and full signed-product sequences.
module tb_multiplier_datapath;

    logic Clk;
    logic Reset;
    multiplier_datapath_if bus ();

    multiplier_datapath dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        string      name;
        logic       rst;
        logic       clr_ld;
        logic       clear_a;
        logic       add;
        logic       sub;
        logic       shift;
        logic [7:0] s;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        logic       exp_x;
    } vec_t;

    vec_t vecs[$];
    int   total;
    int   bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [5:0] cmd, input logic [7:0] s,
                                input logic [7:0] ea, input logic [7:0] eb, input logic ex);
        vec_t v;
        v.name    = name;
        v.rst     = cmd[5];
        v.clr_ld  = cmd[4];
        v.clear_a = cmd[3];
        v.add     = cmd[2];
        v.sub     = cmd[1];
        v.shift   = cmd[0];
        v.s       = s;
        v.exp_a   = ea;
        v.exp_b   = eb;
        v.exp_x   = ex;
        return v;
    endfunction

    // Drive one cycle's command set, clock it in, and settle past the edge.
    task automatic apply(input logic rst, input logic clr_ld, input logic clear_a,
                         input logic add, input logic sub, input logic shift, input logic [7:0] s);
        Reset      = rst;
        bus.Clr_Ld = clr_ld;
        bus.ClearA = clear_a;
        bus.Add    = add;
        bus.Sub    = sub;
        bus.Shift  = shift;
        bus.S      = s;
        @(posedge Clk);
        #1;
    endtask

    task automatic check_regs(input string name, input logic [7:0] ea, input logic [7:0] eb,
                              input logic ex);
        check({name, ".A"}, 32'(bus.Aval), 32'(ea));
        check({name, ".B"}, 32'(bus.Bval), 32'(eb));
        check({name, ".X"}, 32'(bus.X), 32'(ex));
        check({name, ".M"}, 32'(bus.M), 32'(eb[0]));
    endtask

    // Controller-equivalent run: load B, then 8 x (add/sub when M=1, shift), sub on the 8th.
    task automatic run_product(input string name, input logic [7:0] s, input logic [7:0] b,
                               input logic [15:0] exp);
        apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, b);
        for (int i = 0; i < 8; i++) begin
            if (bus.M) begin
                apply(1'b0, 1'b0, 1'b0, (i != 7), (i == 7), 1'b0, s);
            end
            apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, s);
        end
        check(name, 32'({bus.Aval, bus.Bval}), 32'(exp));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        Reset      = 1'b0;
        bus.Clr_Ld = 1'b0;
        bus.ClearA = 1'b0;
        bus.Add    = 1'b0;
        bus.Sub    = 1'b0;
        bus.Shift  = 1'b0;
        bus.S      = 8'h00;
        @(negedge Clk);

        // cmd bits: {rst, clr_ld, clear_a, add, sub, shift}
        vecs.push_back(mk("reset_over_load",  6'b110000, 8'h55, 8'h00, 8'h00, 1'b0));
        vecs.push_back(mk("clear_a",          6'b001000, 8'h00, 8'h00, 8'h00, 1'b0));
        vecs.push_back(mk("add_80",           6'b000100, 8'h80, 8'h80, 8'h00, 1'b1));
        vecs.push_back(mk("add_92_to_112",    6'b000100, 8'h92, 8'h12, 8'h00, 1'b1));
        vecs.push_back(mk("clear_and_load",   6'b011000, 8'h07, 8'h00, 8'h07, 1'b0));
        vecs.push_back(mk("add_c5",           6'b000100, 8'hC5, 8'hC5, 8'h07, 1'b1));
        vecs.push_back(mk("shift_after_add",  6'b000001, 8'hC5, 8'hE2, 8'h83, 1'b1));
        vecs.push_back(mk("clear_a_2",        6'b001000, 8'h07, 8'h00, 8'h83, 1'b0));
        vecs.push_back(mk("sub_0_minus_7",    6'b000010, 8'h07, 8'hF9, 8'h83, 1'b1));
        vecs.push_back(mk("clear_a_3",        6'b001000, 8'h05, 8'h00, 8'h83, 1'b0));
        vecs.push_back(mk("add_05",           6'b000100, 8'h05, 8'h05, 8'h83, 1'b0));
        vecs.push_back(mk("sub_5_minus_5",    6'b000010, 8'h05, 8'h00, 8'h83, 1'b0));
        vecs.push_back(mk("load_over_sub",    6'b010010, 8'h40, 8'h00, 8'h40, 1'b0));
        vecs.push_back(mk("add_01",           6'b000100, 8'h01, 8'h01, 8'h40, 1'b0));
        vecs.push_back(mk("add_over_shift",   6'b000101, 8'h01, 8'h02, 8'h40, 1'b0));
        vecs.push_back(mk("sub_over_add",     6'b000110, 8'h01, 8'h01, 8'h40, 1'b0));
        vecs.push_back(mk("clear_over_shift", 6'b001001, 8'h01, 8'h00, 8'h40, 1'b0));

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].clr_ld, vecs[i].clear_a, vecs[i].add, vecs[i].sub,
                  vecs[i].shift, vecs[i].s);
            check_regs(vecs[i].name, vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_x);
        end

        // Idle cycles, with S wiggling to show it is ignored without a command.
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'(8'hA5 + i));
            check_regs($sformatf("hold_%0d", i), 8'h00, 8'h40, 1'b0);
        end

        // Reset wins over every other command mid-run.
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);
        check_regs("pre_reset_add", 8'hFF, 8'h40, 1'b1);
        apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h7F);
        check_regs("reset_mid_run", 8'h00, 8'h00, 1'b0);

        run_product("prod_fd_x_05", 8'hFD, 8'h05, 16'hFFF1);
        run_product("prod_07_x_fd", 8'h07, 8'hFD, 16'hFFEB);
        run_product("prod_80_x_80", 8'h80, 8'h80, 16'h4000);
        run_product("prod_7f_x_7f", 8'h7F, 8'h7F, 16'h3F01);
        run_product("prod_0b_x_00", 8'h0B, 8'h00, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
